// File: rtl/gray_mem_arbiter.sv
// gray_mem_arbiter: two-port round-robin read arbiter with burst lock for the 128x128 gray image memory.
// Define GRAY_ARB_STATS_EN to add the saturating gnt_cnt0 / gnt_cnt1 / stall_cnt counter outputs.
module gray_mem_arbiter #(
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [13:0] addr0,
  input  logic        lock0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [7:0]  rdata0,
  input  logic        req1,
  input  logic [13:0] addr1,
  input  logic        lock1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [7:0]  rdata1,
  output logic        mem_rd,
  output logic [13:0] mem_addr,
  input  logic [7:0]  mem_data
`ifdef GRAY_ARB_STATS_EN
  ,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [1:0] ST_ARB    = 2'd0;
  localparam logic [1:0] ST_LOCK0  = 2'd1;
  localparam logic [1:0] ST_LOCK1  = 2'd2;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam int         LAST      = MEM_LAT - 1;

  logic [1:0]         state_r, state_nx_s;
  logic               rr_ptr_r, rr_nx_s;
  logic [3:0]         burst_cnt_r, cnt_nx_s, cnt_inc_s;
  logic               gnt0_s, gnt1_s, xfer_s;
  logic               own_s, own_lock_s, gnt_lock_s;
  logic               mem_rd_r;
  logic [13:0]        mem_addr_r;
  logic [MEM_LAT-1:0] pipe_v_r, pipe_tag_r;
  logic               ret_v_s, ret_tag_s;
  logic               rvalid0_r, rvalid1_r;
  logic [7:0]         rdata0_r, rdata1_r;

  assign xfer_s     = gnt0_s | gnt1_s;
  assign own_s      = (state_r == ST_LOCK1);
  assign own_lock_s = own_s ? lock1 : lock0;
  assign gnt_lock_s = gnt1_s ? lock1 : lock0;
  assign cnt_inc_s  = burst_cnt_r + 4'd1;

  // Grant decode: round-robin in ARB, exclusive owner in LOCK states.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case (state_r)
      ST_ARB: begin
        if (req0 && req1) begin
          if (rr_ptr_r) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end else if (req0) begin
          gnt0_s = 1'b1;
        end else if (req1) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      end
      ST_LOCK0: gnt0_s = req0;
      ST_LOCK1: gnt1_s = req1;
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  assign gnt0 = gnt0_s & reset_n;
  assign gnt1 = gnt1_s & reset_n;

  // Next-state, round-robin pointer and burst length bookkeeping.
  always_comb begin
    state_nx_s = state_r;
    rr_nx_s    = rr_ptr_r;
    cnt_nx_s   = burst_cnt_r;
    case (state_r)
      ST_ARB: begin
        if (xfer_s) begin
          if (req0 && req1) begin
            rr_nx_s = ~gnt1_s;
          end else begin
            rr_nx_s = rr_ptr_r;
          end
          if (gnt_lock_s) begin
            cnt_nx_s = 4'd1;
            // A cap of one means the lock is already exhausted by this grant.
            if (BURST_MAX <= 4'd1) begin
              state_nx_s = ST_ARB;
              rr_nx_s    = ~gnt1_s;
            end else begin
              state_nx_s = gnt1_s ? ST_LOCK1 : ST_LOCK0;
            end
          end else begin
            cnt_nx_s   = 4'd0;
            state_nx_s = ST_ARB;
          end
        end else begin
          state_nx_s = ST_ARB;
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (xfer_s) begin
          if (cnt_inc_s >= BURST_MAX) begin
            state_nx_s = ST_ARB;
            rr_nx_s    = ~own_s;
            cnt_nx_s   = 4'd0;
          end else if (!own_lock_s) begin
            state_nx_s = ST_ARB;
            cnt_nx_s   = 4'd0;
          end else begin
            cnt_nx_s   = cnt_inc_s;
          end
        end else if (!own_lock_s) begin
          state_nx_s = ST_ARB;
          cnt_nx_s   = 4'd0;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = ST_ARB;
        rr_nx_s    = 1'b0;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_ARB;
      rr_ptr_r    <= 1'b0;
      burst_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_nx_s;
      rr_ptr_r    <= rr_nx_s;
      burst_cnt_r <= cnt_nx_s;
    end
  end

  // Memory issue: address is captured only on the transfer edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd_r   <= 1'b0;
      mem_addr_r <= 14'd0;
    end else begin
      mem_rd_r <= xfer_s;
      if (xfer_s) begin
        mem_addr_r <= gnt1_s ? addr1 : addr0;
      end
    end
  end

  // Owner tag pipeline, one stage per cycle of memory latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v_r   <= '0;
      pipe_tag_r <= '0;
    end else begin
      pipe_v_r[0]   <= xfer_s;
      pipe_tag_r[0] <= gnt1_s;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v_r[i]   <= pipe_v_r[i-1];
        pipe_tag_r[i] <= pipe_tag_r[i-1];
      end
    end
  end

  assign ret_v_s   = pipe_v_r[LAST];
  assign ret_tag_s = pipe_tag_r[LAST];

  // Return path: capture mem_data for the tagged owner, other port holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= 8'd0;
      rdata1_r  <= 8'd0;
    end else begin
      rvalid0_r <= ret_v_s & ~ret_tag_s;
      rvalid1_r <= ret_v_s & ret_tag_s;
      if (ret_v_s && !ret_tag_s) begin
        rdata0_r <= mem_data;
      end
      if (ret_v_s && ret_tag_s) begin
        rdata1_r <= mem_data;
      end
    end
  end

  assign mem_rd   = mem_rd_r;
  assign mem_addr = mem_addr_r;
  assign rvalid0  = rvalid0_r;
  assign rvalid1  = rvalid1_r;
  assign rdata0   = rdata0_r;
  assign rdata1   = rdata1_r;

`ifdef GRAY_ARB_STATS_EN
  logic [15:0] gnt_cnt0_r, gnt_cnt1_r, stall_cnt_r;
  logic        stall_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      return v + 16'd1;
    end else begin
      return v;
    end
  endfunction

  assign stall_s = (req0 & ~gnt0_s) | (req1 & ~gnt1_s);

  // Saturating transfer and stall counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_cnt0_r  <= 16'd0;
      gnt_cnt1_r  <= 16'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      gnt_cnt0_r  <= sat_inc(gnt_cnt0_r, gnt0_s);
      gnt_cnt1_r  <= sat_inc(gnt_cnt1_r, gnt1_s);
      stall_cnt_r <= sat_inc(stall_cnt_r, stall_s);
    end
  end

  assign gnt_cnt0  = gnt_cnt0_r;
  assign gnt_cnt1  = gnt_cnt1_r;
  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Bench for gray_mem_arbiter: two instances (MEM_LAT=1/MAX_BURST=9 and MEM_LAT=3/MAX_BURST=4)
// share one stimulus stream and are checked every cycle against a rule-level model.
module tb_gray_mem_arbiter;

  localparam int LAT_A = 1;
  localparam int MB_A  = 9;
  localparam int LAT_B = 3;
  localparam int MB_B  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req0, lock0, req1, lock1;
  logic [13:0] addr0, addr1;

  logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_rd_a;
  logic [7:0]  rdata0_a, rdata1_a, mem_data_a;
  logic [13:0] mem_addr_a;
  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_rd_b;
  logic [7:0]  rdata0_b, rdata1_b, mem_data_b;
  logic [13:0] mem_addr_b;
`ifdef GRAY_ARB_STATS_EN
  logic [15:0] gc0_a, gc1_a, st_a, gc0_b, gc1_b, st_b;
`endif

  gray_mem_arbiter #(.MEM_LAT(LAT_A), .MAX_BURST(MB_A)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
    .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
    .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a)
`ifdef GRAY_ARB_STATS_EN
    , .gnt_cnt0(gc0_a), .gnt_cnt1(gc1_a), .stall_cnt(st_a)
`endif
  );

  gray_mem_arbiter #(.MEM_LAT(LAT_B), .MAX_BURST(MB_B)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b)
`ifdef GRAY_ARB_STATS_EN
    , .gnt_cnt0(gc0_b), .gnt_cnt1(gc1_b), .stall_cnt(st_b)
`endif
  );

  // Memory model: data for the address presented MEM_LAT-1 cycles earlier.
  logic [7:0]  mem_arr [0:16383];
  logic [13:0] dly1, dly2;
  always @(posedge clk) begin
    dly1 <= mem_addr_b;
    dly2 <= dly1;
  end
  assign mem_data_a = mem_arr[mem_addr_a];
  assign mem_data_b = mem_arr[dly2];

  // Per-instance views for the compare process.
  logic [1:0]       gnt0_v, gnt1_v, rv0_v, rv1_v, mrd_v;
  logic [1:0][7:0]  rd0_v, rd1_v;
  logic [1:0][13:0] maddr_v;
  assign gnt0_v  = {gnt0_b, gnt0_a};
  assign gnt1_v  = {gnt1_b, gnt1_a};
  assign rv0_v   = {rvalid0_b, rvalid0_a};
  assign rv1_v   = {rvalid1_b, rvalid1_a};
  assign mrd_v   = {mem_rd_b, mem_rd_a};
  assign rd0_v   = {rdata0_b, rdata0_a};
  assign rd1_v   = {rdata1_b, rdata1_a};
  assign maddr_v = {mem_addr_b, mem_addr_a};
`ifdef GRAY_ARB_STATS_EN
  logic [1:0][15:0] gc0_v, gc1_v, st_v;
  assign gc0_v = {gc0_b, gc0_a};
  assign gc1_v = {gc1_b, gc1_a};
  assign st_v  = {st_b, st_a};
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  // Behavioural model state: owner -1 means nobody holds the lock.
  int          cyc = 0;
  int          owner [2];
  int          run [2];
  int          prefer [2];
  logic        e_mrd [2];
  logic [13:0] e_maddr [2];
  logic        e_rv0 [2], e_rv1 [2];
  logic [7:0]  e_rd0 [2], e_rd1 [2];
  logic        pv [2][8];
  int          pp [2][8];
  logic [13:0] pa [2][8];
  int          e_gc0 [2], e_gc1 [2], e_st [2];

  always @(negedge clk) begin
    int g, o, mb, lat, slot;
    logic ol;
    for (int k = 0; k < 2; k++) begin
      mb  = (k == 0) ? MB_A : MB_B;
      lat = (k == 0) ? LAT_A : LAT_B;
      if (!reset_n) begin
        chk("rst_gnt0", k, gnt0_v[k], 0);
        chk("rst_gnt1", k, gnt1_v[k], 0);
        chk("rst_mem_rd", k, mrd_v[k], 0);
        chk("rst_mem_addr", k, maddr_v[k], 0);
        chk("rst_rvalid0", k, rv0_v[k], 0);
        chk("rst_rvalid1", k, rv1_v[k], 0);
        chk("rst_rdata0", k, rd0_v[k], 0);
        chk("rst_rdata1", k, rd1_v[k], 0);
        owner[k] = -1; run[k] = 0; prefer[k] = 0;
        e_mrd[k] = 1'b0; e_maddr[k] = 14'd0;
        e_rv0[k] = 1'b0; e_rv1[k] = 1'b0; e_rd0[k] = 8'd0; e_rd1[k] = 8'd0;
        for (int s = 0; s < 8; s++) pv[k][s] = 1'b0;
        e_gc0[k] = 0; e_gc1[k] = 0; e_st[k] = 0;
      end else begin
        if (owner[k] < 0) begin
          if (req0 && req1) g = prefer[k];
          else if (req0) g = 0;
          else if (req1) g = 1;
          else g = -1;
        end else begin
          g = ((owner[k] == 0) ? req0 : req1) ? owner[k] : -1;
        end
        chk("gnt0", k, gnt0_v[k], (g == 0));
        chk("gnt1", k, gnt1_v[k], (g == 1));
        chk("mem_rd", k, mrd_v[k], e_mrd[k]);
        chk("mem_addr", k, maddr_v[k], e_maddr[k]);
        chk("rvalid0", k, rv0_v[k], e_rv0[k]);
        chk("rvalid1", k, rv1_v[k], e_rv1[k]);
        chk("rdata0", k, rd0_v[k], e_rd0[k]);
        chk("rdata1", k, rd1_v[k], e_rd1[k]);
`ifdef GRAY_ARB_STATS_EN
        chk("gnt_cnt0", k, gc0_v[k], e_gc0[k]);
        chk("gnt_cnt1", k, gc1_v[k], e_gc1[k]);
        chk("stall_cnt", k, st_v[k], e_st[k]);
`endif
        if (g == 0 && e_gc0[k] < 65535) e_gc0[k]++;
        if (g == 1 && e_gc1[k] < 65535) e_gc1[k]++;
        if (((req0 && g != 0) || (req1 && g != 1)) && e_st[k] < 65535) e_st[k]++;
        // Ownership rules for the next cycle.
        if (owner[k] < 0) begin
          if (g >= 0) begin
            if (req0 && req1) prefer[k] = 1 - g;
            if ((g == 0) ? lock0 : lock1) begin
              run[k] = 1;
              if (run[k] >= mb) prefer[k] = 1 - g;
              else owner[k] = g;
            end
          end
        end else begin
          o  = owner[k];
          ol = (o == 0) ? lock0 : lock1;
          if (g == o) begin
            run[k]++;
            if (run[k] >= mb) begin
              owner[k]  = -1;
              prefer[k] = 1 - o;
            end else if (!ol) begin
              owner[k] = -1;
            end
          end else if (!ol) begin
            owner[k] = -1;
          end
        end
        // Issue and return schedule: data lands MEM_LAT+1 cycles after the grant.
        e_mrd[k] = (g >= 0);
        if (g >= 0) begin
          e_maddr[k] = (g == 0) ? addr0 : addr1;
          slot = (cyc + lat + 1) % 8;
          pv[k][slot] = 1'b1;
          pp[k][slot] = g;
          pa[k][slot] = e_maddr[k];
        end
        slot = (cyc + 1) % 8;
        e_rv0[k] = 1'b0;
        e_rv1[k] = 1'b0;
        if (pv[k][slot]) begin
          pv[k][slot] = 1'b0;
          if (pp[k][slot] == 0) begin
            e_rv0[k] = 1'b1;
            e_rd0[k] = mem_arr[pa[k][slot]];
          end else begin
            e_rv1[k] = 1'b1;
            e_rd1[k] = mem_arr[pa[k][slot]];
          end
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic l0, input logic r1, input logic l1,
                       input logic [13:0] a0, input logic [13:0] a1);
    req0 = r0; lock0 = l0; req1 = r1; lock1 = l1; addr0 = a0; addr1 = a1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [13:0] ia;
    logic [10:0] pat_a, pat_b;
    int          nrv;
    for (int i = 0; i < 16384; i++) begin
      ia = 14'(i);
      mem_arr[i] = ia[7:0] ^ {ia[13:8], 2'b00};
    end
    mem_arr[14'h0081] = 8'h5A;
    mem_arr[14'h0010] = 8'h10;
    mem_arr[14'h0020] = 8'h20;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single read from port 0.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 14'h0081, 14'h0000);
    @(negedge clk);
    chk("t1_gnt0", 0, gnt0_a, 1);
    chk("t1_gnt1", 0, gnt1_a, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000);
    @(negedge clk);
    chk("t1_mem_rd", 0, mem_rd_a, 1);
    chk("t1_mem_addr", 0, mem_addr_a, 14'h0081);
    tick();
    @(negedge clk);
    chk("t1_rvalid0", 0, rvalid0_a, 1);
    chk("t1_rdata0", 0, rdata0_a, 8'h5A);
    chk("t1_rvalid1", 0, rvalid1_a, 0);
    tick();
    @(negedge clk);
    chk("t1_pulse_end", 0, rvalid0_a, 0);
    chk("t1_rdata_hold", 0, rdata0_a, 8'h5A);
    tick();
    @(negedge clk);
    chk("t1_b_rvalid0", 1, rvalid0_b, 1);
    chk("t1_b_rdata0", 1, rdata0_b, 8'h5A);
    chk("t1_b_rvalid1", 1, rvalid1_b, 0);
    repeat (3) tick();

    // Contention: alternating grants starting with port 0.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 14'h0010, 14'h0020);
      @(negedge clk);
      chk("t2_gnt0", 0, gnt0_a, (i % 2 == 0));
      chk("t2_gnt1", 0, gnt1_a, (i % 2 == 1));
      chk("t2_gnt0", 1, gnt0_b, (i % 2 == 0));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000);
    @(negedge clk);
`ifdef GRAY_ARB_STATS_EN
    chk("t2_gnt_cnt0", 0, gc0_a, 16'd5);
    chk("t2_gnt_cnt1", 0, gc1_a, 16'd5);
    chk("t2_stall_cnt", 0, st_a, 16'd10);
`endif
    repeat (6) tick();
    @(negedge clk);
    chk("t2_rdata0", 0, rdata0_a, 8'h10);
    chk("t2_rdata1", 0, rdata1_a, 8'h20);
    chk("t2_rdata1", 1, rdata1_b, 8'h20);
    tick();

    // Lock burst with cap: port 0 holds lock while port 1 keeps requesting.
    do_reset();
    pat_a = 11'h200;
    pat_b = 11'h210;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 14'h0100 + 14'(i), 14'h0040);
      @(negedge clk);
      chk("t3_gnt1", 0, gnt1_a, pat_a[i]);
      chk("t3_gnt0", 0, gnt0_a, !pat_a[i]);
      chk("t4_gnt1", 1, gnt1_b, pat_b[i]);
      chk("t4_gnt0", 1, gnt0_b, !pat_b[i]);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000);
    repeat (6) tick();

    // Lock held while idle, then released; address changes without grant ignored.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 14'h0300, 14'h0400);
    @(negedge clk);
    chk("th_gnt0", 0, gnt0_a, 1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 14'h0301, 14'h0401);
    @(negedge clk);
    chk("th_hold_gnt1", 0, gnt1_a, 0);
    chk("th_hold_gnt0", 0, gnt0_a, 0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 14'h0302, 14'h0402);
    @(negedge clk);
    chk("th_release_gnt1", 0, gnt1_a, 0);
    chk("th_mem_rd_idle", 0, mem_rd_a, 0);
    chk("th_mem_addr_hold", 0, mem_addr_a, 14'h0300);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 14'h0303, 14'h0403);
    @(negedge clk);
    chk("th_arb_gnt1", 0, gnt1_a, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000);
    @(negedge clk);
    chk("th_mem_addr", 0, mem_addr_a, 14'h0403);
    repeat (6) tick();

    // Reset one cycle after two grants drops everything in flight.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 14'h0500, 14'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 14'h0600);
    tick();
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 14'h0501, 14'h0601);
    @(negedge clk);
    chk("t5_gnt0_in_reset", 0, gnt0_a, 0);
    chk("t5_gnt1_in_reset", 1, gnt1_b, 0);
    chk("t5_rvalid0", 0, rvalid0_a, 0);
    chk("t5_mem_addr", 1, mem_addr_b, 14'h0000);
    tick();
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000);
    nrv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nrv += int'(rvalid0_a) + int'(rvalid1_a) + int'(rvalid0_b) + int'(rvalid1_b);
      tick();
    end
    chk("t5_no_rvalid", 0, nrv, 0);

    // Mixed directed traffic checked by the model.
    for (int i = 0; i < 40; i++) begin
      drive((i % 3) != 2, (i % 7) == 1, (i % 4) != 0, (i % 5) == 3,
            14'h0200 + 14'(i), 14'h3000 + 14'(i * 3));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 14'h0000);
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
